// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- parametrised UART receiver (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits) with a valid/ready output register and per-word
// error flags.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   : each bit is the 2-of-3 majority of samples at CLK_MID-1,
//               CLK_MID and CLK_MID+1; the decision is made at CLK_MID+1.
//   undefined : single sample at CLK_MID; the decision is made at CLK_MID.
//
// Ports:
//   i_Clk        sole clock
//   i_reset      synchronous, active-high reset
//   i_serial     asynchronous serial line, idles high
//   o_rx_data    received word, LSB-aligned, unused upper bits are 0
//   o_rx_valid   o_rx_data and the error flags are valid
//   i_rx_ready   consumer accepts the word when o_rx_valid && i_rx_ready
//   o_frame_err  a stop bit sampled 0
//   o_parity_err parity mismatch (always 0 when PARITY=0)
//   o_break      data, parity and first stop all sampled 0
//   o_overrun    one-cycle pulse: a completed frame was dropped
module uart_rx_ext #(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_HZ    = 25000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic       i_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_break,
  output logic       o_overrun
);

  localparam int CLK_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int CLK_MID     = (CLK_PER_BIT - 1) / 2;
  localparam int CW          = $clog2(CLK_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_PT      = CLK_MID + 1;
`else
  localparam int DEC_PT      = CLK_MID;
`endif

  localparam logic [CW-1:0] CNT_DEC   = CW'(DEC_PT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic          hist_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          zero_q;     // every bit sampled so far in this frame was 0
  logic          fe_q;
  logic          pe_q;
  logic          brk_q;

  logic rx_s;
  logic fall_d;
  logic bit_d;
  logic tick_d;
  logic wrap_d;
  logic fe_d;
  logic brk_d;

  assign rx_s   = sync_q[1];
  assign fall_d = hist_q & ~rx_s;
  assign tick_d = (clk_cnt_q == CNT_DEC);
  assign wrap_d = (clk_cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_M0 = CW'(CLK_MID - 1);
  localparam logic [CW-1:0] CNT_M1 = CW'(CLK_MID);
  logic [1:0] smp_q;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      smp_q <= '0;
    end else begin
      if (clk_cnt_q == CNT_M0) smp_q[0] <= rx_s;
      if (clk_cnt_q == CNT_M1) smp_q[1] <= rx_s;
    end
  end

  assign bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
`else
  assign bit_d = rx_s;
`endif

  // Break is decided on the first stop bit; a second stop bit only adds to
  // the frame error.
  assign fe_d  = fe_q | ~bit_d;
  assign brk_d = (bit_idx_q == 3'd0) ? (zero_q & ~bit_d) : brk_q;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      hist_q       <= 1'b1;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      zero_q       <= 1'b1;
      fe_q         <= 1'b0;
      pe_q         <= 1'b0;
      brk_q        <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_serial};
      hist_q    <= sync_q[1];
      o_overrun <= 1'b0;

      // Acceptance clears the word; a completion below in the same cycle
      // overrides this with the new word.
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;

      if (state_q == S_IDLE) clk_cnt_q <= '0;
      else if (wrap_d)       clk_cnt_q <= '0;
      else                   clk_cnt_q <= clk_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          bit_idx_q <= '0;
          shift_q   <= '0;
          zero_q    <= 1'b1;
          fe_q      <= 1'b0;
          pe_q      <= 1'b0;
          brk_q     <= 1'b0;
          if (fall_d) state_q <= S_START;
        end
        S_START: begin
          if (tick_d && bit_d) state_q <= S_IDLE;
          else if (wrap_d)     state_q <= S_DATA;
        end
        S_DATA: begin
          if (tick_d) begin
            shift_q[bit_idx_q] <= bit_d;
            zero_q             <= zero_q & ~bit_d;
          end
          if (wrap_d) begin
            if (bit_idx_q == LAST_DATA) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick_d) begin
            pe_q   <= ((^shift_q) ^ bit_d) != PAR_ODD;
            zero_q <= zero_q & ~bit_d;
          end
          if (wrap_d) state_q <= S_STOP;
        end
        S_STOP: begin
          if (tick_d) begin
            fe_q  <= fe_d;
            brk_q <= brk_d;
            // Completing on the decision cycle leaves the rest of the stop
            // bit for IDLE, so back-to-back frames are caught.
            if (bit_idx_q == LAST_STOP) begin
              state_q <= S_IDLE;
              if (!o_rx_valid || i_rx_ready) begin
                o_rx_data    <= shift_q;
                o_frame_err  <= fe_d;
                o_parity_err <= pe_q;
                o_break      <= brk_d;
                o_rx_valid   <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end
          end
          if (wrap_d) bit_idx_q <= bit_idx_q + 3'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
